// File: rtl/rr_packet_arbiter.sv
// Packet-granular TX arbiter: merges NUM_USERS user streams onto one registered
// output channel, using round-robin with per-user packet quotas or fixed priority.
module rr_packet_arbiter #(
    parameter int NUM_USERS  = 4,
    parameter int USER_BITS  = 2,
    parameter int LINE_WIDTH = 512,
    parameter int QUOTA_BITS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [LINE_WIDTH-1:0]            usr_tx_lines [NUM_USERS],
    input  logic [NUM_USERS-1:0]             usr_tx_last,
    input  logic [NUM_USERS-1:0]             usr_tx_valid,
    output logic [NUM_USERS-1:0]             usr_tx_ready,
    input  logic [NUM_USERS*QUOTA_BITS-1:0]  cfg_quota,
    input  logic                             cfg_fixed_prio,
    output logic [LINE_WIDTH-1:0]            arb_tx_line,
    output logic [USER_BITS-1:0]             arb_tx_tag,
    output logic                             arb_tx_last,
    output logic                             arb_tx_valid,
    input  logic                             arb_tx_ready,
    output logic [1:0]                       dbg_state
);

    // Handshake: a beat moves on a channel in the cycle where valid and ready
    // are both high; valid never depends on ready, ready may depend on valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state;
    logic [USER_BITS-1:0]    rr_ptr;
    logic [USER_BITS-1:0]    owner;
    logic [QUOTA_BITS-1:0]   pkt_cnt;

    logic                    load_en;
    logic                    win_found;
    logic [USER_BITS-1:0]    win_idx;
    int                      cand;
    logic [USER_BITS-1:0]    cand_idx;
    logic                    gnt_any;
    logic [USER_BITS-1:0]    gnt_idx;
    logic                    accept;
    logic                    gnt_last;
    logic                    new_turn;
    logic [QUOTA_BITS-1:0]   base_cnt;
    logic [QUOTA_BITS-1:0]   cnt_inc;
    logic [QUOTA_BITS-1:0]   quota_raw;
    logic [QUOTA_BITS-1:0]   quota_eff;
    logic                    quota_done;
    logic [USER_BITS-1:0]    next_rr;

    assign load_en   = ~arb_tx_valid | arb_tx_ready;
    assign dbg_state = state;

    // Winner search: upward from rr_ptr with wrap, or from index 0 in fixed mode.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_USERS; k++) begin
            cand     = cfg_fixed_prio ? k : (int'(rr_ptr) + k) % NUM_USERS;
            cand_idx = USER_BITS'(cand);
            if (!win_found && usr_tx_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        gnt_any = win_found;
        gnt_idx = win_idx;
        unique case (state)
            BUSY: begin
                gnt_any = 1'b1;
                gnt_idx = owner;
            end
            HOLD: begin
                if (usr_tx_valid[owner]) begin
                    gnt_any = 1'b1;
                    gnt_idx = owner;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_USERS; i++) begin
            usr_tx_ready[i] = rst_n & load_en & gnt_any & (gnt_idx == USER_BITS'(i));
        end
    end

    assign accept     = rst_n & load_en & gnt_any & usr_tx_valid[gnt_idx];
    assign gnt_last   = usr_tx_last[gnt_idx];
    assign new_turn   = (state == IDLE) || ((state == HOLD) && (gnt_idx != owner));
    assign base_cnt   = new_turn ? '0 : pkt_cnt;
    assign cnt_inc    = base_cnt + QUOTA_BITS'(1);
    assign quota_raw  = cfg_quota[int'(gnt_idx)*QUOTA_BITS +: QUOTA_BITS];
    assign quota_eff  = (quota_raw == '0) ? QUOTA_BITS'(1) : quota_raw;
    assign quota_done = (cnt_inc >= quota_eff);
    assign next_rr    = USER_BITS'((int'(gnt_idx) + 1) % NUM_USERS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            pkt_cnt      <= '0;
            arb_tx_valid <= 1'b0;
            arb_tx_line  <= '0;
            arb_tx_tag   <= '0;
            arb_tx_last  <= 1'b0;
        end else begin
            if (load_en) begin
                arb_tx_valid <= accept;
                if (accept) begin
                    arb_tx_line <= usr_tx_lines[gnt_idx];
                    arb_tx_tag  <= gnt_idx;
                    arb_tx_last <= gnt_last;
                end
            end
            if (accept) begin
                owner <= gnt_idx;
                if (!gnt_last) begin
                    state   <= BUSY;
                    pkt_cnt <= base_cnt;
                end else if (quota_done) begin
                    state   <= IDLE;
                    pkt_cnt <= '0;
                    rr_ptr  <= next_rr;
                end else begin
                    state   <= HOLD;
                    pkt_cnt <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Bench for rr_packet_arbiter: vector table, directed corner sequences and a
// randomized run against a turn-based reference model with a beat scoreboard.
module tb_rr_packet_arbiter;

    localparam int N   = 4;
    localparam int UB  = 2;
    localparam int LW  = 512;
    localparam int QB  = 4;
    localparam int SBW = UB + 1 + LW;

    logic              clk;
    logic              rst_n;
    logic [LW-1:0]     usr_tx_lines [N];
    logic [N-1:0]      usr_tx_last;
    logic [N-1:0]      usr_tx_valid;
    logic [N-1:0]      usr_tx_ready;
    logic [N*QB-1:0]   cfg_quota;
    logic              cfg_fixed_prio;
    logic [LW-1:0]     arb_tx_line;
    logic [UB-1:0]     arb_tx_tag;
    logic              arb_tx_last;
    logic              arb_tx_valid;
    logic              arb_tx_ready;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    rr_packet_arbiter #(
        .NUM_USERS(N), .USER_BITS(UB), .LINE_WIDTH(LW), .QUOTA_BITS(QB)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .usr_tx_lines(usr_tx_lines), .usr_tx_last(usr_tx_last),
        .usr_tx_valid(usr_tx_valid), .usr_tx_ready(usr_tx_ready),
        .cfg_quota(cfg_quota), .cfg_fixed_prio(cfg_fixed_prio),
        .arb_tx_line(arb_tx_line), .arb_tx_tag(arb_tx_tag),
        .arb_tx_last(arb_tx_last), .arb_tx_valid(arb_tx_valid),
        .arb_tx_ready(arb_tx_ready), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [SBW-1:0] act, input logic [SBW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a user's "turn" spans its packets until quota is used up.
    logic [SBW-1:0] exp_q[$];
    bit m_ov;
    bit m_in_pkt;
    int m_turn;
    int m_pkts;
    int m_rr;

    task automatic model_reset();
        m_ov = 0; m_in_pkt = 0; m_turn = -1; m_pkts = 0; m_rr = 0;
        exp_q.delete();
    endtask

    function automatic bit vbit(input int u);
        return usr_tx_valid[UB'(u)];
    endfunction

    function automatic int model_pick();
        int u;
        if (m_in_pkt) return m_turn;
        if (m_turn >= 0 && vbit(m_turn)) return m_turn;
        for (int k = 0; k < N; k++) begin
            u = cfg_fixed_prio ? k : (m_rr + k) % N;
            if (vbit(u)) return u;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [N-1:0] m_rdy;
        bit le, acc;
        int g, q;
        le = !m_ov || arb_tx_ready;
        g  = model_pick();
        m_rdy = '0;
        if (le && g >= 0) m_rdy[UB'(g)] = 1'b1;
        chk("rand_rdy", SBW'(usr_tx_ready), SBW'(m_rdy));
        chk("rand_ov", SBW'(arb_tx_valid), SBW'(m_ov));
        if (arb_tx_valid && arb_tx_ready) begin
            chk("rand_sb_nonempty", SBW'(exp_q.size() != 0), SBW'(1));
            if (exp_q.size() != 0)
                chk("rand_beat", {arb_tx_tag, arb_tx_last, arb_tx_line}, exp_q.pop_front());
        end
        acc = le && g >= 0 && vbit(g);
        if (acc) begin
            exp_q.push_back({UB'(g), usr_tx_last[UB'(g)], usr_tx_lines[UB'(g)]});
            if (g != m_turn) begin
                m_turn = g;
                m_pkts = 0;
            end
            if (usr_tx_last[UB'(g)]) begin
                m_in_pkt = 0;
                m_pkts++;
                q = int'(cfg_quota[g*QB +: QB]);
                if (q == 0) q = 1;
                if (m_pkts >= q) begin
                    m_turn = -1;
                    m_pkts = 0;
                    m_rr   = (g + 1) % N;
                end
            end else begin
                m_in_pkt = 1;
            end
        end
        if (le) m_ov = acc;
    endtask

    // Driver tasks
    task automatic do_reset();
        rst_n = 1'b0;
        usr_tx_valid = '0;
        usr_tx_last  = '0;
        arb_tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  last;
        logic [N-1:0]  exp_rdy;
        logic          exp_ov;
        logic [UB-1:0] exp_tag;
        logic          exp_last;
    } vec_t;

    vec_t vecs[13];
    int   qexp[9];
    int   bp_pat[10];

    initial begin
        logic [N-1:0]   e;
        logic [SBW-1:0] prev_word;
        bit             prev_stall;
        int             bi, nb;

        rst_n = 1'b0;
        cfg_fixed_prio = 1'b0;
        cfg_quota = {QB'(1), QB'(1), QB'(1), QB'(1)};
        arb_tx_ready = 1'b1;
        for (int i = 0; i < N; i++) usr_tx_lines[i] = LW'(i + 16);

        // Round-robin single-beat packets, then a 4-beat lock by user 1.
        vecs[0]  = '{4'b1111, 4'b1111, 4'b0001, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b1111, 4'b0010, 1'b1, 2'd0, 1'b1};
        vecs[2]  = '{4'b1111, 4'b1111, 4'b0100, 1'b1, 2'd1, 1'b1};
        vecs[3]  = '{4'b1111, 4'b1111, 4'b1000, 1'b1, 2'd2, 1'b1};
        vecs[4]  = '{4'b1111, 4'b1111, 4'b0001, 1'b1, 2'd3, 1'b1};
        vecs[5]  = '{4'b0111, 4'b0000, 4'b0010, 1'b1, 2'd0, 1'b1};
        vecs[6]  = '{4'b0111, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[7]  = '{4'b0111, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[8]  = '{4'b0111, 4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0};
        vecs[9]  = '{4'b0101, 4'b0101, 4'b0100, 1'b1, 2'd1, 1'b1};
        vecs[10] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd2, 1'b1};
        vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b1};
        vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        qexp   = '{0, 0, 1, 2, 3, 3, 3, 0, 0};
        bp_pat = '{1, 1, 0, 0, 1, 1, 0, 1, 1, 1};

        do_reset();
        #1;
        chk("reset_ov", SBW'(arb_tx_valid), SBW'(0));
        chk("reset_out", {arb_tx_tag, arb_tx_last, arb_tx_line}, '0);
        chk("reset_state", SBW'(dbg_state), SBW'(0));

        for (int i = 0; i < 13; i++) begin
            usr_tx_valid = vecs[i].valid;
            usr_tx_last  = vecs[i].last;
            #1;
            chk($sformatf("tbl_rdy[%0d]", i), SBW'(usr_tx_ready), SBW'(vecs[i].exp_rdy));
            chk($sformatf("tbl_ov[%0d]", i), SBW'(arb_tx_valid), SBW'(vecs[i].exp_ov));
            if (vecs[i].exp_ov)
                chk($sformatf("tbl_tag_last[%0d]", i), SBW'({arb_tx_tag, arb_tx_last}),
                    SBW'({vecs[i].exp_tag, vecs[i].exp_last}));
            @(negedge clk);
        end

        // Quota: user0=2, user1=1, user2=1, user3=3.
        cfg_quota = {QB'(3), QB'(1), QB'(1), QB'(2)};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            usr_tx_valid = 4'b1111;
            usr_tx_last  = 4'b1111;
            #1;
            e = '0;
            e[UB'(qexp[k])] = 1'b1;
            chk($sformatf("quota_gnt[%0d]", k), SBW'(usr_tx_ready), SBW'(e));
            if (k > 0)
                chk($sformatf("quota_tag[%0d]", k), SBW'(arb_tx_tag), SBW'(qexp[k-1]));
            @(negedge clk);
        end

        // HOLD fallback: user 0 keeps its turn but drops valid; user 3 takes over at once.
        cfg_quota = {QB'(1), QB'(1), QB'(1), QB'(4)};
        do_reset();
        usr_tx_valid = 4'b0001; usr_tx_last = 4'b0001;
        #1 chk("hold_first_gnt", SBW'(usr_tx_ready), SBW'(4'b0001));
        @(negedge clk);
        usr_tx_valid = 4'b1000; usr_tx_last = 4'b1000;
        #1 chk("hold_fallback_gnt", SBW'(usr_tx_ready), SBW'(4'b1000));
        chk("hold_out0", SBW'({arb_tx_valid, arb_tx_tag}), SBW'({1'b1, 2'd0}));
        @(negedge clk);
        usr_tx_valid = 4'b0000;
        #1 chk("hold_no_bubble", SBW'({arb_tx_valid, arb_tx_tag}), SBW'({1'b1, 2'd3}));
        @(negedge clk);

        // Backpressure on a 3-beat packet from user 2.
        cfg_quota = {QB'(1), QB'(1), QB'(1), QB'(1)};
        do_reset();
        bi = 0; nb = 0; prev_stall = 0; prev_word = '0;
        for (int c = 0; c < 10; c++) begin
            usr_tx_valid = (bi < 3) ? 4'b0100 : 4'b0000;
            usr_tx_last  = (bi == 2) ? 4'b0100 : 4'b0000;
            usr_tx_lines[2] = LW'(100 + bi);
            arb_tx_ready = bp_pat[c][0];
            #1;
            if (prev_stall) begin
                chk("bp_stable", {arb_tx_tag, arb_tx_last, arb_tx_line}, prev_word);
                chk("bp_valid_held", SBW'(arb_tx_valid), SBW'(1));
            end
            if (arb_tx_valid && !arb_tx_ready)
                chk("bp_stall_rdy", SBW'(usr_tx_ready), SBW'(0));
            if (arb_tx_valid && arb_tx_ready) begin
                chk("bp_beat", {arb_tx_tag, arb_tx_last, arb_tx_line},
                    {2'd2, (nb == 2), LW'(100 + nb)});
                nb++;
            end
            if (usr_tx_ready[2] && usr_tx_valid[2]) bi++;
            prev_stall = arb_tx_valid && !arb_tx_ready;
            prev_word  = {arb_tx_tag, arb_tx_last, arb_tx_line};
            @(negedge clk);
        end
        chk("bp_beat_count", SBW'(nb), SBW'(3));
        chk("bp_beats_sent", SBW'(bi), SBW'(3));

        // Fixed priority, then reset in the middle of a user 1 packet.
        arb_tx_ready = 1'b1;
        do_reset();
        cfg_fixed_prio = 1'b1;
        for (int k = 0; k < 4; k++) begin
            usr_tx_valid = 4'b1010; usr_tx_last = 4'b1010;
            #1 chk($sformatf("fp_gnt[%0d]", k), SBW'(usr_tx_ready), SBW'(4'b0010));
            if (k > 0) chk($sformatf("fp_tag[%0d]", k), SBW'(arb_tx_tag), SBW'(1));
            @(negedge clk);
        end
        usr_tx_last = 4'b0000;
        #1 chk("fp_pkt_start", SBW'(usr_tx_ready), SBW'(4'b0010));
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_rdy_low", SBW'(usr_tx_ready), SBW'(0));
        @(negedge clk);
        #1 chk("rst_ov", SBW'(arb_tx_valid), SBW'(0));
        chk("rst_rdy_held", SBW'(usr_tx_ready), SBW'(0));
        rst_n = 1'b1;
        cfg_fixed_prio = 1'b0;
        usr_tx_valid = 4'b1001; usr_tx_last = 4'b1001;
        #1 chk("post_rst_gnt", SBW'(usr_tx_ready), SBW'(4'b0001));
        @(negedge clk);

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 97 == 0)
                for (int i = 0; i < N; i++) cfg_quota[i*QB +: QB] = QB'($urandom_range(0, 3));
            if (c % 500 == 250) cfg_fixed_prio = ~cfg_fixed_prio;
            usr_tx_valid = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                usr_tx_last[i]  = ($urandom_range(0, 2) == 0);
                usr_tx_lines[i] = rand_line();
            end
            arb_tx_ready = ($urandom_range(0, 3) != 0);
            #1 model_step();
            @(negedge clk);
        end
        usr_tx_valid = '0;
        arb_tx_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 model_step();
            @(negedge clk);
        end
        chk("rand_sb_drained", SBW'(exp_q.size()), SBW'(0));

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
- Next-generation round-robin TX arbiter for the fthread shell. Merges NUM_USERS user TX streams onto one channel.
- Grants whole packets: once a user starts a packet, the grant stays with it until the beat flagged last.
- A per-user quota sets how many packets a user may send back-to-back before the grant rotates. A fixed-priority mode is also available.
- Output is registered (one-deep pipeline slice) so the wide data mux is not on the downstream timing path.

Parameters:
- NUM_USERS, 4, number of user channels (≥2).
- USER_BITS, 2, width of the user index/tag; must equal clog2(NUM_USERS).
- LINE_WIDTH, 512, data beat width.
- QUOTA_BITS, 4, width of each per-user packet quota field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- usr_tx_lines  in  LINE_WIDTH x NUM_USERS (unpacked array)  per-user data beat.
- usr_tx_last  in  NUM_USERS  per-user end-of-packet flag, qualified by usr_tx_valid.
- usr_tx_valid  in  NUM_USERS  per-user beat valid.
- usr_tx_ready  out  NUM_USERS  per-user beat accepted; combinational.
- cfg_quota  in  NUM_USERS*QUOTA_BITS  packets per turn for user i, in bits [i*QUOTA_BITS +: QUOTA_BITS]; 0 is treated as 1.
- cfg_fixed_prio  in  1  1 = fixed priority (lowest index wins); 0 = round-robin.
- arb_tx_line  out  LINE_WIDTH  registered output beat.
- arb_tx_tag  out  USER_BITS  source user of the output beat.
- arb_tx_last  out  1  end-of-packet flag of the output beat.
- arb_tx_valid  out  1  output beat valid.
- arb_tx_ready  in  1  downstream ready.

Behaviour:
- Reset:
  - arb_tx_valid=0, arb_tx_line=0, arb_tx_tag=0, arb_tx_last=0.
  - State IDLE, rr_ptr=0, owner=0, pkt_cnt=0.
  - An assertion of rst_n mid-packet abandons the packet. There is no flush and no resume.
- Output slice:
  - load_en = ~arb_tx_valid | arb_tx_ready.
  - When load_en is high and a beat is accepted, the output registers take line/tag/last and arb_tx_valid is set to 1.
  - When load_en is high and no beat is accepted, arb_tx_valid is cleared to 0.
  - When load_en is low, the output registers hold their contents.
  - Latency: 1 cycle from acceptance to arb_tx_valid. Throughput: 1 beat/cycle under continuous ready.
- Acceptance: usr_tx_ready[i] = load_en & grant[i], with at most one grant bit set. A beat is accepted when usr_tx_valid[i] & usr_tx_ready[i].
- Winner selection (used in IDLE):
  - cfg_fixed_prio=0: first valid user searching upward from rr_ptr, with wrap-around (rr_ptr, rr_ptr+1, …, NUM_USERS-1, 0, …).
  - cfg_fixed_prio=1: lowest valid index; rr_ptr is ignored.
- States:
  - IDLE:
    - grant = selected winner (none if no user is valid).
    - Accepted beat with last=0 → BUSY, owner=winner, pkt_cnt=0.
    - Accepted beat with last=1 → pkt_cnt=1, owner=winner, then apply the quota check.
  - BUSY:
    - grant = owner only. Other users are starved even if valid.
    - Owner not valid → wait; the packet is never preempted.
    - Accepted last beat → pkt_cnt+1, then apply the quota check.
  - HOLD:
    - grant = owner if usr_tx_valid[owner]; otherwise grant = winner of an IDLE-style selection, in the same cycle.
    - If the owner sends, behave as in IDLE but keep the owner and pkt_cnt.
    - If another user wins, pkt_cnt restarts at 0 for the new owner and rr_ptr is updated on that user's release.
- Quota check (after each accepted last beat):
  - q = max(cfg_quota[owner], 1).
  - pkt_cnt reaches q → release: state IDLE, rr_ptr=(owner+1) mod NUM_USERS, pkt_cnt=0.
  - Otherwise → HOLD.
- Counter width: pkt_cnt is QUOTA_BITS wide; the compare uses the incremented value and never wraps, since q ≤ 2^QUOTA_BITS-1.
- Simultaneous events: a last beat accepted while the output is stalled cannot happen, because ready is gated by load_en. Arbitration and state advance only on accepted beats.
- cfg_quota and cfg_fixed_prio are sampled every cycle. A change takes effect at the next packet boundary and never splits a packet.
- Reset mid-operation must not generate spurious usr_tx_ready while rst_n=0: all ready outputs are 0 during reset.

Test Plan:
- Round-robin, single-beat packets:
  - Stimulus: all 4 users valid with last=1 continuously, quota=1, ready=1.
  - Required: tags out 0,1,2,3,0,1…; one beat per cycle after a 1-cycle latency.
- Packet lock:
  - Stimulus: user 1 sends a 4-beat packet while user 0 and user 2 are valid.
  - Required: 4 consecutive tag=1 beats, last only on beat 4; user 2 is granted next, not user 0.
- Quota:
  - Stimulus: cfg_quota = {3,1,1,2} for users {3,2,1,0}; all users continuously valid with 1-beat packets.
  - Required: tag sequence 0,0,1,2,3,3,3,0,0….
- HOLD fallback:
  - Stimulus: user 0 quota=4; user 0 sends 1 packet then drops valid; user 3 is valid.
  - Required: next grant is user 3 in the same cycle, with no idle bubble.
- Backpressure:
  - Stimulus: toggle arb_tx_ready 1,0,0,1 during a 3-beat packet.
  - Required: arb_tx_line/tag/last are stable while valid=1 and ready=0; no beats are lost or duplicated; usr_tx_ready=0 while stalled.
- Fixed-priority and reset:
  - Stimulus: cfg_fixed_prio=1 with users 1 and 3 valid; then assert rst_n=0 mid-packet.
  - Required: only tag 1 is granted before reset; after reset, arb_tx_valid=0, all usr_tx_ready=0, and arbitration restarts from user 0.
